// File: rtl/ifetch_unit_if.sv
// ifetch_unit_if: bundles the fetch stage's control, flag and instruction
// memory signals. The slave modport is the fetch unit itself; the master
// modport is whatever drives it (datapath, control unit, imem).
// Optional macro IFU_JR_EN adds the register-indirect jump signals.
interface ifetch_unit_if;
  logic        stall;
  logic        halt_req;
  logic        resume;
  logic        branch;
  logic [1:0]  br_type;
  logic        jump;
  logic        zero;
  logic        msb;
  logic [31:0] imem_data;
  logic [31:0] imem_addr;
  logic [31:0] inst;
  logic [31:0] pc_plus4;
  logic        halted;
`ifdef IFU_JR_EN
  logic        jr;
  logic [31:0] jr_target;
`endif

  modport slave (
`ifdef IFU_JR_EN
    input  jr, jr_target,
`endif
    input  stall, halt_req, resume, branch, br_type, jump, zero, msb,
    input  imem_data,
    output imem_addr, inst, pc_plus4, halted
  );

  modport master (
`ifdef IFU_JR_EN
    output jr, jr_target,
`endif
    output stall, halt_req, resume, branch, br_type, jump, zero, msb,
    output imem_data,
    input  imem_addr, inst, pc_plus4, halted
  );
endinterface

// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch stage for the single-cycle datapath.
// Holds the PC, drives the instruction memory address, hands the fetched
// instruction to the datapath and picks the next PC from jump/branch decode.
// A BOOT/RUN/HALT run-control FSM gives a reset bubble, stall and halt.
// Optional macro IFU_JR_EN adds jr/jr_target with top next-PC priority.
module ifetch_unit #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  ifetch_unit_if.slave bus
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] pc_q;
  logic [31:0] pc_plus4_w;
  logic [31:0] next_pc;
  logic [31:0] inst_w;
  logic [31:0] br_offset;
  logic        br_taken;
  logic        pc_en;
  logic        halted_w;

  // Run-control state register; reset drops into the BOOT bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: stall only blocks the RUN->HALT transition, never BOOT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (!bus.stall && bus.halt_req) begin
          state_d = HALT;
        end
      end
      HALT: begin
        if (bus.resume) begin
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // State-dependent outputs: memory data only reaches the datapath in RUN.
  always_comb begin
    inst_w   = NOP_INST;
    halted_w = 1'b0;
    pc_en    = 1'b0;
    case (state_q)
      RUN: begin
        inst_w = bus.imem_data;
        pc_en  = !bus.stall;
      end
      HALT: begin
        halted_w = 1'b1;
      end
      default: begin
        inst_w   = NOP_INST;
        halted_w = 1'b0;
        pc_en    = 1'b0;
      end
    endcase
  end

  // Branch condition from the ALU flags of the instruction being executed.
  always_comb begin
    br_taken = 1'b0;
    case (bus.br_type)
      2'b00: br_taken = bus.zero;
      2'b01: br_taken = !bus.zero;
      2'b10: br_taken = !bus.msb && !bus.zero;
      2'b11: br_taken = bus.msb;
      default: br_taken = 1'b0;
    endcase
  end

  assign pc_plus4_w = pc_q + 32'd4;
  assign br_offset  = {{14{inst_w[15]}}, inst_w[15:0], 2'b00};

  // Next-PC select: (jr) > jump > taken branch > sequential, all modulo 2^32.
  always_comb begin
    next_pc = pc_plus4_w;
`ifdef IFU_JR_EN
    if (bus.jr) begin
      next_pc = bus.jr_target & 32'hFFFF_FFFC;
    end else if (bus.jump) begin
      next_pc = {pc_plus4_w[31:28], inst_w[25:0], 2'b00};
    end else if (bus.branch && br_taken) begin
      next_pc = pc_plus4_w + br_offset;
    end
`else
    if (bus.jump) begin
      next_pc = {pc_plus4_w[31:28], inst_w[25:0], 2'b00};
    end else if (bus.branch && br_taken) begin
      next_pc = pc_plus4_w + br_offset;
    end
`endif
  end

  // PC register: advances only in RUN without stall, so BOOT and HALT hold it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= PC_RESET;
    end else if (pc_en) begin
      pc_q <= next_pc;
    end
  end

  assign bus.imem_addr = pc_q;
  assign bus.inst      = inst_w;
  assign bus.pc_plus4  = pc_plus4_w;
  assign bus.halted    = halted_w;

endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed-vector bench for ifetch_unit. The main instance
// boots at 0x100; two extra instances boot at 0x3000_0010 and 0xFFFF_FFFC
// to reach the high-region jump and the PC wrap-around cases.
// Optional macro IFU_JR_EN enables the register-indirect jump vector.
module tb_ifetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic clk;
  logic rst;
  int   n_compared;
  int   n_mismatched;

  ifetch_unit_if ifc ();
  ifetch_unit_if ifc_hi ();
  ifetch_unit_if ifc_wr ();

  ifetch_unit #(.PC_RESET(32'h0000_0100), .NOP_INST(NOP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  ifetch_unit #(.PC_RESET(32'h3000_0010), .NOP_INST(NOP)) dut_hi (
    .clk (clk),
    .rst (rst),
    .bus (ifc_hi)
  );

  ifetch_unit #(.PC_RESET(32'hFFFF_FFFC), .NOP_INST(NOP)) dut_wr (
    .clk (clk),
    .rst (rst),
    .bus (ifc_wr)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] data, input logic br, input logic [1:0] bt,
                               input logic j, input logic z, input logic m,
                               input logic st, input logic hr, input logic rs);
    ifc.imem_data = data;
    ifc.branch    = br;
    ifc.br_type   = bt;
    ifc.jump      = j;
    ifc.zero      = z;
    ifc.msb       = m;
    ifc.stall     = st;
    ifc.halt_req  = hr;
    ifc.resume    = rs;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleAux();
    ifc_hi.stall = 1'b0; ifc_hi.halt_req = 1'b0; ifc_hi.resume = 1'b0;
    ifc_hi.branch = 1'b0; ifc_hi.br_type = 2'b00; ifc_hi.jump = 1'b0;
    ifc_hi.zero = 1'b0; ifc_hi.msb = 1'b0; ifc_hi.imem_data = NOP;
    ifc_wr.stall = 1'b0; ifc_wr.halt_req = 1'b0; ifc_wr.resume = 1'b0;
    ifc_wr.branch = 1'b0; ifc_wr.br_type = 2'b00; ifc_wr.jump = 1'b0;
    ifc_wr.zero = 1'b0; ifc_wr.msb = 1'b0; ifc_wr.imem_data = NOP;
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    rst = 1'b1;
`ifdef IFU_JR_EN
    ifc.jr = 1'b0;    ifc.jr_target = 32'h0;
    ifc_hi.jr = 1'b0; ifc_hi.jr_target = 32'h0;
    ifc_wr.jr = 1'b0; ifc_wr.jr_target = 32'h0;
`endif
    idleAux();
    applyStimulus(32'hDEAD_BEEF, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Reset state, observed while reset is held
    #12;
    checkOutput("rst_addr", ifc.imem_addr, 32'h0000_0100);
    checkOutput("rst_inst", ifc.inst, NOP);
    checkOutput("rst_pc4", ifc.pc_plus4, 32'h0000_0104);
    checkOutput("rst_halted", {31'b0, ifc.halted}, 32'h0);
    rst = 1'b0;
    #1;
    checkOutput("boot_inst", ifc.inst, NOP);

    // BOOT -> RUN even with stall high; PC_RESET is the first fetch
    tick();
    checkOutput("first_addr", ifc.imem_addr, 32'h0000_0100);
    checkOutput("first_inst", ifc.inst, 32'hDEAD_BEEF);
    checkOutput("hi_boot_addr", ifc_hi.imem_addr, 32'h3000_0010);
    checkOutput("wr_boot_addr", ifc_wr.imem_addr, 32'hFFFF_FFFC);
    checkOutput("wr_pc4", ifc_wr.pc_plus4, 32'h0000_0000);

    // j with inst[25:0]=0x40 in the 0x3 region; wrap instance steps sequentially
    ifc_hi.imem_data = 32'h0800_0040;
    ifc_hi.jump      = 1'b1;
    applyStimulus(NOP, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("seq_104", ifc.imem_addr, 32'h0000_0104);
    checkOutput("hi_jump", ifc_hi.imem_addr, 32'h3000_0100);
    checkOutput("wr_wrap", ifc_wr.imem_addr, 32'h0000_0000);

    // jump and taken beq together: jump target wins
    ifc_hi.imem_data = 32'h0800_0080;
    ifc_hi.branch    = 1'b1;
    ifc_hi.br_type   = 2'b00;
    ifc_hi.zero      = 1'b1;
    tick();
    checkOutput("seq_108", ifc.imem_addr, 32'h0000_0108);
    checkOutput("hi_jump_over_br", ifc_hi.imem_addr, 32'h3000_0200);
    idleAux();

    // Jump to 0x200
    applyStimulus(32'h0800_0080, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("jump_200", ifc.imem_addr, 32'h0000_0200);

    // beq imm=-1 zero=1 -> self loop
    applyStimulus(32'h1000_FFFF, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("beq_taken", ifc.imem_addr, 32'h0000_0200);

    // beq zero=0 -> fall through
    applyStimulus(32'h1000_FFFF, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("beq_not", ifc.imem_addr, 32'h0000_0204);

    applyStimulus(32'h0800_0080, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    // bgtz msb=0 zero=0 -> taken
    applyStimulus(32'h1C00_FFFF, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("bgtz_taken", ifc.imem_addr, 32'h0000_0200);

    // bgtz with zero=1 -> not taken
    applyStimulus(32'h1C00_FFFF, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("bgtz_zero", ifc.imem_addr, 32'h0000_0204);

    // bltz msb=1 at 0x204, imm=-2 -> 0x208-8 = 0x200
    applyStimulus(32'h0400_FFFE, 1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("bltz_taken", ifc.imem_addr, 32'h0000_0200);

    // bne zero=1 -> not taken
    applyStimulus(32'h1400_FFFF, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("bne_not", ifc.imem_addr, 32'h0000_0204);

    // Jump to 0x40, then stall three cycles (last with halt_req too)
    applyStimulus(32'h0800_0010, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("jump_40", ifc.imem_addr, 32'h0000_0040);
    applyStimulus(32'h2400_0001, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) ifc.halt_req = 1'b1;
      tick();
      checkOutput("stall_hold", ifc.imem_addr, 32'h0000_0040);
      checkOutput("stall_inst", ifc.inst, 32'h2400_0001);
    end
    checkOutput("stall_halt_run", {31'b0, ifc.halted}, 32'h0);
    applyStimulus(32'h2400_0001, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("stall_release", ifc.imem_addr, 32'h0000_0044);

    // Jump to 0x80 and halt there
    applyStimulus(32'h0800_0020, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("jump_80", ifc.imem_addr, 32'h0000_0080);
    applyStimulus(32'h0000_000D, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("halt_addr", ifc.imem_addr, 32'h0000_0084);
    checkOutput("halt_flag", {31'b0, ifc.halted}, 32'h1);
    checkOutput("halt_inst", ifc.inst, NOP);

    // In HALT, jump/halt_req are ignored and PC stays frozen
    applyStimulus(32'h0800_0040, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    checkOutput("halt_frozen", ifc.imem_addr, 32'h0000_0084);
    checkOutput("halt_still", {31'b0, ifc.halted}, 32'h1);

    // Resume: fetch restarts at 0x84
    applyStimulus(32'h2400_0002, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("resume_flag", {31'b0, ifc.halted}, 32'h0);
    checkOutput("resume_addr", ifc.imem_addr, 32'h0000_0084);
    checkOutput("resume_inst", ifc.inst, 32'h2400_0002);
    applyStimulus(NOP, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("resume_step", ifc.imem_addr, 32'h0000_0088);

`ifdef IFU_JR_EN
    // jr beats jump; low target bits dropped
    applyStimulus(32'h0800_0040, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    ifc.jr        = 1'b1;
    ifc.jr_target = 32'h0000_1237;
    tick();
    checkOutput("jr_target", ifc.imem_addr, 32'h0000_1234);
    ifc.jr = 1'b0;
    applyStimulus(NOP, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

    // Asynchronous reset mid-run takes effect before any clock edge
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst_addr", ifc.imem_addr, 32'h0000_0100);
    checkOutput("midrst_inst", ifc.inst, NOP);
    checkOutput("midrst_halted", {31'b0, ifc.halted}, 32'h0);
    rst = 1'b0;
    tick();
    checkOutput("midrst_first", ifc.imem_addr, 32'h0000_0100);
    tick();
    checkOutput("midrst_step", ifc.imem_addr, 32'h0000_0104);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
